mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the 32K×12 main memory between the CPU and the data-break (DMA) channel. It sits directly in front of the RAM's read/write-request/done handshake and owns that handshake exclusively. Each requester gets a private request/done port with captured read data. The data-break port has fixed priority, bounded by an anti-starvation counter that guarantees the CPU progress.

## Interface
- MAX_DB_BURST, 4: consecutive data-break grants allowed while the CPU is waiting before the CPU is forced a grant; range 1–15.
- TIMEOUT, 64: cycles a granted access may wait for ram_done before the arbiter flags an error.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cpu_rd_req, cpu_wr_req  in  1 each  CPU access request; held until cpu_done.
- cpu_ma  in  15  CPU address.
- cpu_wdata  in  12  CPU write data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  12  captured read data.
- db_rd_req, db_wr_req, db_ma, db_wdata, db_done, db_rdata: same as the CPU port, for data break.
- ram_read_req, ram_write_req  out  1  registered requests to RAM.
- ram_ma  out  15  registered address.
- ram_in  out  12  registered write data.
- ram_done  in  1  RAM completion, one cycle after the request is accepted.
- ram_out  in  12  RAM read data; valid while ram_ma is stable.
- arb_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY_CPU, BUSY_DB.
- IDLE: sample both ports.
  - A port requests if its rd or wr is high.
  - Winner is db, unless the CPU is requesting and db_burst_cnt == MAX_DB_BURST, in which case the winner is the CPU.
- On grant, latch on the same edge:
  - the winner's ma into ram_ma and wdata into ram_in;
  - ram_write_req = wr, ram_read_req = rd & ~wr, so write wins if both are high.
- Then move to the BUSY state for that owner.
- BUSY_x:
  - Hold the RAM request and address.
  - When ram_done = 1, pulse x_done combinationally in that cycle. On the same edge: clear the RAM requests, capture ram_out into x_rdata if the access was a read, and return to IDLE.
- x_rdata holds its value until the next read completes on that port. Writes leave it unchanged.
- db_burst_cnt:
  - increments on each db grant made while cpu_req is high, saturating at MAX_DB_BURST;
  - clears on any CPU grant, and on a db grant with the CPU idle.
- Timeout:
  - A counter runs in BUSY. If it reaches TIMEOUT without ram_done, set arb_err, drop the RAM requests, pulse x_done with x_rdata unchanged, and return to IDLE.
  - arb_err clears only on reset.
- A requester still holding req in the cycle after its done is treated as a new request.
- ram_done arriving in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE;
  - all RAM requests 0, ram_ma 0, ram_in 0;
  - cpu_done and db_done 0, both rdata 0;
  - burst and timeout counters 0, arb_err 0.
- Reset mid-access aborts the access without a done pulse.
- Latency:
  - request seen in cycle 0 (IDLE);
  - ram request high in cycles 1–2;
  - ram_done and x_done in cycle 2;
  - x_rdata valid from cycle 3.
- Back-to-back throughput is one access per 3 cycles (grant, RAM busy, IDLE).
- RAM requests deassert on the edge after ram_done, so the RAM never re-triggers.
- Simultaneous CPU and db requests in IDLE: db wins unless the burst limit has been reached.
- The port address and data need only be stable in the IDLE sample cycle; everything after that is latched.

## Structure
- Shared package tss8_mem_pkg holds:
  - the state enum (IDLE, BUSY_CPU, BUSY_DB);
  - the port-ID constants;
  - address and data width constants (15, 12).
- One sub-module, mem_arb_port, instantiated twice: request decode (write-over-read), done gating and the rdata capture register.
- Arbitration FSM and counters live in mem_arbiter.

## Test plan
- CPU read alone, RAM[01234] = 05670 → ram_read_req in cycles 1–2, cpu_done in cycle 2, cpu_rdata = 05670 from cycle 3; db_done stays 0.
- Simultaneous db write 00777 ← 01111 and CPU read 00777 → db is served first, then the CPU read returns 01111.
- db holds its request continuously while the CPU requests, MAX_DB_BURST = 4 → exactly 4 db grants, then 1 CPU grant, then db resumes.
- Both rd and wr asserted on the CPU port → ram_write_req = 1, ram_read_req = 0, and cpu_rdata is unchanged.
- RAM stub withholds ram_done, TIMEOUT = 64 → at cycle 64 after the grant, arb_err = 1 and a cpu_done pulse; a subsequent normal access completes with arb_err still 1.
- reset asserted during BUSY_DB → next cycle all outputs are at reset values, with no db_done pulse; a fresh request is then served normally.

Source files
------------

// File: rtl/tss8_mem_pkg.sv
// rtl/tss8_mem_pkg.sv - shared types and widths for the main-memory arbiter
package tss8_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DB  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_CPU,
    BUSY_DB
  } arb_state_t;

  function automatic arb_state_t busy_state(input logic port);
    return (port == PORT_DB) ? BUSY_DB : BUSY_CPU;
  endfunction

endpackage

// File: rtl/mem_arb_port.sv
// rtl/mem_arb_port.sv - one requester port: write-over-read decode, done gating, read data capture
module mem_arb_port
  import tss8_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              owner,
  input  logic              finish,
  input  logic              capture,
  input  logic [DATA_W-1:0] ram_out,
  output logic              req,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  assign req    = rd_req | wr_req;
  assign ram_wr = wr_req;
  assign ram_rd = rd_req & ~wr_req;
  assign done   = owner & finish;

  // Only a read that really saw ram_done updates rdata; timeouts and writes leave it alone.
  always_ff @(posedge clk) begin
    if (reset)
      rdata <= '0;
    else if (done && capture)
      rdata <= ram_out;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU / data-break arbiter owning the main-memory request/done handshake
module mem_arbiter
  import tss8_mem_pkg::*;
#(
  parameter int MAX_DB_BURST = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_ma,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              db_rd_req,
  input  logic              db_wr_req,
  input  logic [ADDR_W-1:0] db_ma,
  input  logic [DATA_W-1:0] db_wdata,
  output logic              db_done,
  output logic [DATA_W-1:0] db_rdata,
  output logic              ram_read_req,
  output logic              ram_write_req,
  output logic [ADDR_W-1:0] ram_ma,
  output logic [DATA_W-1:0] ram_in,
  input  logic              ram_done,
  input  logic [DATA_W-1:0] ram_out,
  output logic              arb_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  arb_state_t       state;
  logic [3:0]       burst_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic cpu_req, cpu_ram_wr, cpu_ram_rd;
  logic db_req, db_ram_wr, db_ram_rd;
  logic busy, tmo_hit, finish, capture, burst_full, pick_db;

  assign busy       = (state == BUSY_CPU) || (state == BUSY_DB);
  assign tmo_hit    = busy && !ram_done && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign finish     = !reset && busy && (ram_done || tmo_hit);
  assign capture    = ram_done && ram_read_req;
  assign burst_full = (burst_cnt == 4'(MAX_DB_BURST));
  assign pick_db    = db_req && !(cpu_req && burst_full);

  mem_arb_port u_cpu_port (
    .clk     (clk),
    .reset   (reset),
    .rd_req  (cpu_rd_req),
    .wr_req  (cpu_wr_req),
    .owner   (state == BUSY_CPU),
    .finish  (finish),
    .capture (capture),
    .ram_out (ram_out),
    .req     (cpu_req),
    .ram_wr  (cpu_ram_wr),
    .ram_rd  (cpu_ram_rd),
    .done    (cpu_done),
    .rdata   (cpu_rdata)
  );

  mem_arb_port u_db_port (
    .clk     (clk),
    .reset   (reset),
    .rd_req  (db_rd_req),
    .wr_req  (db_wr_req),
    .owner   (state == BUSY_DB),
    .finish  (finish),
    .capture (capture),
    .ram_out (ram_out),
    .req     (db_req),
    .ram_wr  (db_ram_wr),
    .ram_rd  (db_ram_rd),
    .done    (db_done),
    .rdata   (db_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ram_read_req  <= 1'b0;
      ram_write_req <= 1'b0;
      ram_ma        <= '0;
      ram_in        <= '0;
      burst_cnt     <= '0;
      tmo_cnt       <= '0;
      arb_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || db_req) begin
            state         <= busy_state(pick_db ? PORT_DB : PORT_CPU);
            ram_ma        <= pick_db ? db_ma : cpu_ma;
            ram_in        <= pick_db ? db_wdata : cpu_wdata;
            ram_write_req <= pick_db ? db_ram_wr : cpu_ram_wr;
            ram_read_req  <= pick_db ? db_ram_rd : cpu_ram_rd;
            tmo_cnt       <= '0;
            // A db win over a waiting CPU implies the count is below the limit, so it saturates there.
            if (pick_db && cpu_req)
              burst_cnt <= burst_cnt + 4'd1;
            else
              burst_cnt <= '0;
          end
        end
        BUSY_CPU, BUSY_DB: begin
          if (ram_done || tmo_hit) begin
            state         <= IDLE;
            ram_read_req  <= 1'b0;
            ram_write_req <= 1'b0;
            tmo_cnt       <= '0;
            if (tmo_hit)
              arb_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a RAM stub and transaction model
module tb_mem_arbiter;

  localparam int MAX_DB_BURST = 4;
  localparam int TIMEOUT      = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd_req, cpu_wr_req, db_rd_req, db_wr_req;
  logic [14:0] cpu_ma, db_ma, ram_ma;
  logic [11:0] cpu_wdata, db_wdata, cpu_rdata, db_rdata, ram_in, ram_out;
  logic        cpu_done, db_done, ram_read_req, ram_write_req, ram_done, arb_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DB_BURST(MAX_DB_BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_ma(cpu_ma), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .db_rd_req(db_rd_req), .db_wr_req(db_wr_req), .db_ma(db_ma), .db_wdata(db_wdata),
    .db_done(db_done), .db_rdata(db_rdata),
    .ram_read_req(ram_read_req), .ram_write_req(ram_write_req), .ram_ma(ram_ma), .ram_in(ram_in),
    .ram_done(ram_done), .ram_out(ram_out), .arb_err(arb_err)
  );

  // RAM stub: done one cycle after a request is seen, optional withholding, preload port
  logic [11:0] mem [0:32767];
  logic        withhold = 1'b0;
  logic        pl_en = 1'b0;
  logic [14:0] pl_a = '0;
  logic [11:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (ram_write_req && ram_done) mem[ram_ma] <= ram_in;
    ram_done <= !reset && !withhold && (ram_read_req || ram_write_req) && !ram_done;
  end
  assign ram_out = mem[ram_ma];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr;
    cpu_rd_req = 0; cpu_wr_req = 0; cpu_ma = '0; cpu_wdata = '0;
    db_rd_req = 0; db_wr_req = 0; db_ma = '0; db_wdata = '0;
  endtask

  task automatic preload(input logic [14:0] a, input logic [11:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; clr();
    repeat (2) @(negedge clk);
    vectors++; if ({ram_read_req, ram_write_req, cpu_done, db_done, arb_err} !== 5'b0) begin miscompares++; $display("FAIL reset_flags got %b want 00000", {ram_read_req, ram_write_req, cpu_done, db_done, arb_err}); end
    vectors++; if ({ram_ma, ram_in, cpu_rdata, db_rdata} !== 51'b0) begin miscompares++; $display("FAIL reset_data got ma=%o in=%o crd=%o drd=%o want all 0", ram_ma, ram_in, cpu_rdata, db_rdata); end
    reset = 1'b0;
    preload(15'o01234, 12'o5670);
  endtask

  task automatic test_cpu_read;
    @(negedge clk); cpu_ma = 15'o01234; cpu_rd_req = 1'b1;
    @(negedge clk);
    vectors++; if ({ram_read_req, ram_write_req, cpu_done, db_done} !== 4'b1000) begin miscompares++; $display("FAIL rd_cyc1 got %b want 1000", {ram_read_req, ram_write_req, cpu_done, db_done}); end
    vectors++; if (ram_ma !== 15'o01234) begin miscompares++; $display("FAIL rd_ma got %o want 01234", ram_ma); end
    @(negedge clk);
    vectors++; if ({ram_read_req, cpu_done, db_done} !== 3'b110) begin miscompares++; $display("FAIL rd_cyc2 got %b want 110", {ram_read_req, cpu_done, db_done}); end
    cpu_rd_req = 1'b0;
    @(negedge clk);
    vectors++; if ({ram_read_req, cpu_done, db_done} !== 3'b000) begin miscompares++; $display("FAIL rd_cyc3 got %b want 000", {ram_read_req, cpu_done, db_done}); end
    vectors++; if (cpu_rdata !== 12'o5670) begin miscompares++; $display("FAIL rd_data got %o want 5670", cpu_rdata); end
  endtask

  task automatic test_raw_priority;
    int seq[$];
    @(negedge clk);
    db_ma = 15'o00777; db_wdata = 12'o1111; db_wr_req = 1'b1;
    cpu_ma = 15'o00777; cpu_rd_req = 1'b1;
    for (int k = 0; k < 20 && (cpu_rd_req || db_wr_req); k++) begin
      @(negedge clk);
      if (db_done) begin seq.push_back(1); db_wr_req = 1'b0; end
      if (cpu_done) begin seq.push_back(0); cpu_rd_req = 1'b0; end
    end
    @(negedge clk);
    vectors++; if (seq.size() != 2 || seq[0] != 1 || seq[1] != 0) begin miscompares++; $display("FAIL raw_order got %p want db then cpu", seq); end
    vectors++; if (cpu_rdata !== 12'o1111) begin miscompares++; $display("FAIL raw_data got %o want 1111", cpu_rdata); end
  endtask

  task automatic test_burst;
    int seq[$];
    int want[$];
    for (int i = 0; i < MAX_DB_BURST; i++) want.push_back(1);
    want.push_back(0);
    want.push_back(1);
    @(negedge clk);
    db_ma = 15'o00777; cpu_ma = 15'o00777; db_rd_req = 1'b1; cpu_rd_req = 1'b1;
    for (int k = 0; k < 60 && seq.size() < want.size(); k++) begin
      @(negedge clk);
      if (cpu_done) begin seq.push_back(0); cpu_rd_req = 1'b0; end
      if (db_done) seq.push_back(1);
    end
    db_rd_req = 1'b0; cpu_rd_req = 1'b0;
    vectors++; if (seq != want) begin miscompares++; $display("FAIL burst_seq got %p want %p (1=db 0=cpu)", seq, want); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_both_rd_wr;
    @(negedge clk); cpu_ma = 15'o00100; cpu_wdata = 12'o4321; cpu_rd_req = 1'b1; cpu_wr_req = 1'b1;
    @(negedge clk);
    vectors++; if ({ram_write_req, ram_read_req} !== 2'b10) begin miscompares++; $display("FAIL both_req got wr/rd=%b want 10", {ram_write_req, ram_read_req}); end
    vectors++; if (ram_in !== 12'o4321) begin miscompares++; $display("FAIL both_in got %o want 4321", ram_in); end
    @(negedge clk);
    vectors++; if (cpu_done !== 1'b1) begin miscompares++; $display("FAIL both_done got %b want 1", cpu_done); end
    cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
    @(negedge clk);
    vectors++; if (cpu_rdata !== 12'o1111) begin miscompares++; $display("FAIL both_rdata got %o want 1111", cpu_rdata); end
  endtask

  task automatic test_timeout;
    int done_at;
    done_at = -1;
    withhold = 1'b1;
    @(negedge clk); cpu_ma = 15'o00100; cpu_rd_req = 1'b1;
    for (int k = 1; k <= TIMEOUT + 8; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) begin
        vectors++; if ({arb_err, cpu_done} !== 2'b00) begin miscompares++; $display("FAIL tmo_early got err/done=%b want 00", {arb_err, cpu_done}); end
      end
      if (cpu_done) begin done_at = k; break; end
    end
    cpu_rd_req = 1'b0; withhold = 1'b0;
    vectors++; if (done_at != TIMEOUT) begin miscompares++; $display("FAIL tmo_cycle got %0d want %0d", done_at, TIMEOUT); end
    @(negedge clk);
    vectors++; if ({arb_err, ram_read_req} !== 2'b10) begin miscompares++; $display("FAIL tmo_flag got err/rreq=%b want 10", {arb_err, ram_read_req}); end
    vectors++; if (cpu_rdata !== 12'o1111) begin miscompares++; $display("FAIL tmo_rdata got %o want 1111", cpu_rdata); end
    cpu_ma = 15'o01234; cpu_rd_req = 1'b1;
    done_at = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_done) begin done_at = k; cpu_rd_req = 1'b0; break; end
    end
    cpu_rd_req = 1'b0;
    @(negedge clk);
    vectors++; if (done_at != 2) begin miscompares++; $display("FAIL tmo_after_lat got %0d want 2", done_at); end
    vectors++; if ({arb_err, cpu_rdata} !== {1'b1, 12'o5670}) begin miscompares++; $display("FAIL tmo_after got err=%b data=%o want 1 5670", arb_err, cpu_rdata); end
  endtask

  task automatic test_reset_mid;
    int done_at;
    done_at = -1;
    @(negedge clk); db_ma = 15'o00777; db_rd_req = 1'b1;
    @(negedge clk);
    vectors++; if (ram_read_req !== 1'b1) begin miscompares++; $display("FAIL rst_busy got rreq=%b want 1", ram_read_req); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if ({ram_read_req, ram_write_req, cpu_done, db_done, arb_err} !== 5'b0) begin miscompares++; $display("FAIL rst_flags got %b want 00000", {ram_read_req, ram_write_req, cpu_done, db_done, arb_err}); end
    vectors++; if ({ram_ma, ram_in, cpu_rdata, db_rdata} !== 51'b0) begin miscompares++; $display("FAIL rst_data got ma=%o in=%o crd=%o drd=%o want all 0", ram_ma, ram_in, cpu_rdata, db_rdata); end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (db_done) begin done_at = k; db_rd_req = 1'b0; break; end
    end
    db_rd_req = 1'b0;
    @(negedge clk);
    vectors++; if (done_at != 2) begin miscompares++; $display("FAIL rst_fresh_lat got %0d want 2", done_at); end
    vectors++; if (db_rdata !== 12'o1111) begin miscompares++; $display("FAIL rst_fresh_data got %o want 1111", db_rdata); end
  endtask

  task automatic test_random;
    logic [11:0] shadow [0:7];
    logic        pend [2];
    logic        prd [2];
    logic        pwr [2];
    logic [2:0]  paddr [2];
    logic [11:0] pdata [2];
    logic [11:0] erd [2];
    logic        acc_rd, acc_wr;
    logic [2:0]  acc_addr;
    logic [11:0] acc_data;
    logic [1:0]  exp_req;
    int phase, owner, streak, op;
    for (int i = 0; i < 8; i++) begin
      shadow[i] = 12'($urandom);
      preload(15'(i), shadow[i]);
    end
    pend[0] = 0; pend[1] = 0; erd[0] = '0; erd[1] = 12'o1111;
    phase = 0; owner = 0; streak = 0;
    acc_rd = 0; acc_wr = 0; acc_addr = '0; acc_data = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      vectors++; if ({cpu_done, db_done} !== {phase == 2 && owner == 0, phase == 2 && owner == 1}) begin miscompares++; $display("FAIL rnd_done cyc %0d got cpu/db=%b%b phase %0d owner %0d", cyc, cpu_done, db_done, phase, owner); end
      exp_req = (phase == 0) ? 2'b00 : {acc_wr, acc_rd & ~acc_wr};
      vectors++; if ({ram_write_req, ram_read_req} !== exp_req) begin miscompares++; $display("FAIL rnd_req cyc %0d got wr/rd=%b want %b", cyc, {ram_write_req, ram_read_req}, exp_req); end
      if (phase != 0) begin
        vectors++; if (ram_ma !== {12'b0, acc_addr}) begin miscompares++; $display("FAIL rnd_ma cyc %0d got %o want %o", cyc, ram_ma, acc_addr); end
        if (acc_wr) begin
          vectors++; if (ram_in !== acc_data) begin miscompares++; $display("FAIL rnd_in cyc %0d got %o want %o", cyc, ram_in, acc_data); end
        end
      end
      vectors++; if ({cpu_rdata, db_rdata} !== {erd[0], erd[1]}) begin miscompares++; $display("FAIL rnd_rdata cyc %0d got %o/%o want %o/%o", cyc, cpu_rdata, db_rdata, erd[0], erd[1]); end
      if (phase == 2) begin
        if (acc_wr) shadow[acc_addr] = acc_data;
        else erd[owner] = shadow[acc_addr];
        pend[owner] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) < ((p == 1) ? 3 : 2)) begin
          op = $urandom_range(0, 3);
          pend[p] = 1'b1; prd[p] = (op != 2); pwr[p] = (op >= 2);
          paddr[p] = 3'($urandom); pdata[p] = 12'($urandom);
        end
      end
      cpu_rd_req = pend[0] & prd[0]; cpu_wr_req = pend[0] & pwr[0];
      cpu_ma = pend[0] ? {12'b0, paddr[0]} : 15'($urandom); cpu_wdata = pdata[0];
      db_rd_req = pend[1] & prd[1]; db_wr_req = pend[1] & pwr[1];
      db_ma = pend[1] ? {12'b0, paddr[1]} : 15'($urandom); db_wdata = pdata[1];
      if (phase == 1) phase = 2;
      else if (phase == 2) phase = 0;
      else if (pend[0] || pend[1]) begin
        if (pend[1] && !(pend[0] && streak == MAX_DB_BURST)) begin
          owner = 1;
          streak = pend[0] ? streak + 1 : 0;
        end else begin
          owner = 0;
          streak = 0;
        end
        acc_rd = prd[owner]; acc_wr = pwr[owner]; acc_addr = paddr[owner]; acc_data = pdata[owner];
        phase = 1;
      end
    end
    clr();
    repeat (4) @(negedge clk);
    vectors++; if (arb_err !== 1'b0) begin miscompares++; $display("FAIL rnd_err got %b want 0", arb_err); end
  endtask

  initial begin
    reset = 1'b1;
    clr();
    test_reset();
    test_cpu_read();
    test_raw_priority();
    test_burst();
    test_both_rd_wr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
